// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter (LSL/LSR/ASR/ROR) with valid/ready handshakes.
// Resolves LEVELS_PER_CYCLE shift-amount bits per clock; all outputs are registered.
module seq_shifter #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned LEVELS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           m,
    input  logic [$clog2(WIDTH)-1:0]   n,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       carry,
    output logic                       zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned L   = (SHW + LEVELS_PER_CYCLE - 1) / LEVELS_PER_CYCLE;
    localparam logic [SHW-1:0] L_CNT = SHW'(L);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   n_q;
    logic [1:0]       mode_q;
    logic             sign_q;
    logic             carry_pend;
    logic [SHW-1:0]   lvl_cnt;
    logic [WIDTH-1:0] next_data;
    logic             accept_carry;

    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] d,
        input int unsigned      s,
        input logic [1:0]       md,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] ext;
        ext = {{WIDTH{sgn}}, d} >> s;
        case (md)
            MODE_LSL: shift_once = d << s;
            MODE_LSR: shift_once = d >> s;
            MODE_ASR: shift_once = ext[WIDTH-1:0];
            default:  shift_once = (d >> s) | (d << (WIDTH - s));
        endcase
    endfunction

    // Apply the current group of levels, LSB level first; the last group may be short.
    always_comb begin
        next_data = data_q;
        for (int unsigned j = 0; j < LEVELS_PER_CYCLE; j++) begin
            int unsigned lvl;
            lvl = int'(lvl_cnt) * LEVELS_PER_CYCLE + j;
            if (lvl < SHW) begin
                if (n_q[lvl]) begin
                    next_data = shift_once(next_data, 1 << lvl, mode_q, sign_q);
                end
            end
        end
    end

    // ROR's carry, result[WIDTH-1], is the same operand bit as LSR's: m[n-1].
    always_comb begin
        accept_carry = 1'b0;
        if (n != '0) begin
            if (mode == MODE_LSL) begin
                accept_carry = m[WIDTH - int'(n)];
            end else begin
                accept_carry = m[n - 1'b1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            data_q     <= '0;
            n_q        <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            carry_pend <= 1'b0;
            lvl_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= m;
                        n_q        <= n;
                        mode_q     <= mode;
                        sign_q     <= m[WIDTH-1];
                        carry_pend <= accept_carry;
                        lvl_cnt    <= '0;
                        in_ready   <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // L shifting edges, then one extra edge publishes the result.
                    if (lvl_cnt == L_CNT) begin
                        result    <= data_q;
                        carry     <= carry_pend;
                        zero      <= (data_q == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        data_q  <= next_data;
                        lvl_cnt <= lvl_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed-vector bench for seq_shifter: serial instance (L=5) and full-parallel instance (L=1).
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [31:0] a_m = '0, a_result;
    logic [4:0]  a_n = '0;
    logic [1:0]  a_mode = '0;
    logic        a_carry, a_zero;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [31:0] b_m = '0, b_result;
    logic [4:0]  b_n = '0;
    logic [1:0]  b_mode = '0;
    logic        b_carry, b_zero;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .LEVELS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .m(a_m), .n(a_n), .mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result), .carry(a_carry), .zero(a_zero)
    );

    seq_shifter #(.WIDTH(32), .LEVELS_PER_CYCLE(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .m(b_m), .n(b_n), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .carry(b_carry), .zero(b_zero)
    );

    // Issues one request, returns outputs seen at out_valid and edges from accept to out_valid.
    task automatic run_op(input bit par, input logic [31:0] mv, input logic [4:0] nv,
                          input logic [1:0] md, output logic [31:0] res, output logic cy,
                          output logic z, output int lat);
        int w = 0;
        if (par) begin b_m = mv; b_n = nv; b_mode = md; b_in_valid = 1'b1; end
        else     begin a_m = mv; a_n = nv; a_mode = md; a_in_valid = 1'b1; end
        while (!(par ? b_in_ready : a_in_ready) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 20) begin
            compared++; mismatched++;
            $display("FAIL run_op_ready_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        lat = 0;
        while (!(par ? b_out_valid : a_out_valid) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 50) begin
            compared++; mismatched++;
            $display("FAIL run_op_valid_timeout: out_valid stayed 0, required 1");
        end
        res = par ? b_result : a_result;
        cy  = par ? b_carry  : a_carry;
        z   = par ? b_zero   : a_zero;
        if (par) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        compared++; if (a_result !== 32'h0) begin mismatched++; $display("FAIL reset_result: got %h want 00000000", a_result); end
        compared++; if (a_carry !== 1'b0 || a_zero !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got c=%b z=%b want c=0 z=0", a_carry, a_zero); end
        compared++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_par: got rdy=%b vld=%b want 1 0", b_in_ready, b_out_valid); end
    endtask

    task automatic test_lsl();
        logic [31:0] r; logic c, z; int lat;
        run_op(1'b0, 32'h000000F0, 5'd4, 2'b00, r, c, z, lat);
        compared++; if (r !== 32'h00000F00) begin mismatched++; $display("FAIL lsl_result: got %h want 00000f00", r); end
        compared++; if (c !== 1'b0 || z !== 1'b0) begin mismatched++; $display("FAIL lsl_flags: got c=%b z=%b want c=0 z=0", c, z); end
        compared++; if (lat != 6) begin mismatched++; $display("FAIL lsl_latency: got %0d want 6", lat); end
        compared++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin mismatched++; $display("FAIL lsl_return_idle: got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_asr_lsr();
        logic [31:0] r; logic c, z; int lat;
        run_op(1'b0, 32'hF0000000, 5'd4, 2'b10, r, c, z, lat);
        compared++; if (r !== 32'hFF000000) begin mismatched++; $display("FAIL asr_result: got %h want ff000000", r); end
        compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL asr_carry: got %b want 0", c); end
        run_op(1'b0, 32'h80000001, 5'd1, 2'b01, r, c, z, lat);
        compared++; if (r !== 32'h40000000) begin mismatched++; $display("FAIL lsr_result: got %h want 40000000", r); end
        compared++; if (c !== 1'b1) begin mismatched++; $display("FAIL lsr_carry: got %b want 1", c); end
        run_op(1'b0, 32'h80000000, 5'd31, 2'b10, r, c, z, lat);
        compared++; if (r !== 32'hFFFFFFFF || c !== 1'b0) begin mismatched++; $display("FAIL asr_max: got %h c=%b want ffffffff c=0", r, c); end
    endtask

    task automatic test_ror_lsl_carry();
        logic [31:0] r; logic c, z; int lat;
        run_op(1'b0, 32'h0000000F, 5'd8, 2'b11, r, c, z, lat);
        compared++; if (r !== 32'h0F000000) begin mismatched++; $display("FAIL ror_result: got %h want 0f000000", r); end
        compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL ror_carry: got %b want 0", c); end
        run_op(1'b0, 32'h80000000, 5'd1, 2'b00, r, c, z, lat);
        compared++; if (r !== 32'h0) begin mismatched++; $display("FAIL lsl_out_result: got %h want 00000000", r); end
        compared++; if (c !== 1'b1) begin mismatched++; $display("FAIL lsl_out_carry: got %b want 1", c); end
        compared++; if (z !== 1'b1) begin mismatched++; $display("FAIL lsl_out_zero: got %b want 1", z); end
        run_op(1'b0, 32'h12345678, 5'd4, 2'b11, r, c, z, lat);
        compared++; if (r !== 32'h81234567 || c !== 1'b1) begin mismatched++; $display("FAIL ror_wrap: got %h c=%b want 81234567 c=1", r, c); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r0; logic c0, z0; int w = 0;
        a_m = 32'hFFFF0000; a_n = 5'd16; a_mode = 2'b01; a_in_valid = 1'b1;
        while (!a_in_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        // Keep a different request pending; it must wait and must not disturb the first.
        a_m = 32'h00000003; a_n = 5'd1; a_mode = 2'b11;
        w = 0;
        while (!a_out_valid && w < 50) begin @(posedge clk); #1; w++; end
        compared++; if (!a_out_valid) begin mismatched++; $display("FAIL bp_valid_timeout: got out_valid=0 want 1"); end
        r0 = a_result; c0 = a_carry; z0 = a_zero;
        compared++; if (r0 !== 32'h0000FFFF || c0 !== 1'b0 || z0 !== 1'b0) begin mismatched++; $display("FAIL bp_first_result: got %h c=%b z=%b want 0000ffff c=0 z=0", r0, c0, z0); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            compared++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_result !== r0 || a_carry !== c0 || a_zero !== z0) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b res=%h c=%b z=%b want vld=1 rdy=0 res=%h c=%b z=%b",
                         i, a_out_valid, a_in_ready, a_result, a_carry, a_zero, r0, c0, z0);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        compared++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_idle_after_hs: got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        compared++; if (a_in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_held_accept: got rdy=%b want 0", a_in_ready); end
        w = 0;
        while (!a_out_valid && w < 50) begin @(posedge clk); #1; w++; end
        compared++; if (a_result !== 32'h80000001 || a_carry !== 1'b1) begin mismatched++; $display("FAIL bp_second_result: got %h c=%b want 80000001 c=1", a_result, a_carry); end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic c, z; int lat; int seen = 0;
        a_m = 32'h0000FFFF; a_n = 5'd3; a_mode = 2'b00; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        compared++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_result !== 32'h0) begin mismatched++; $display("FAIL midrst_state: got rdy=%b vld=%b res=%h want 1 0 00000000", a_in_ready, a_out_valid, a_result); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL midrst_no_valid: got %0d valid cycles want 0", seen); end
        run_op(1'b0, 32'h00000001, 5'd31, 2'b00, r, c, z, lat);
        compared++; if (r !== 32'h80000000 || c !== 1'b0 || z !== 1'b0) begin mismatched++; $display("FAIL midrst_new_req: got %h c=%b z=%b want 80000000 c=0 z=0", r, c, z); end
    endtask

    task automatic test_parallel();
        logic [31:0] r; logic c, z; int lat;
        run_op(1'b1, 32'h0F000000, 5'd8, 2'b01, r, c, z, lat);
        compared++; if (r !== 32'h000F0000 || c !== 1'b0) begin mismatched++; $display("FAIL par_lsr_result: got %h c=%b want 000f0000 c=0", r, c); end
        compared++; if (lat != 2) begin mismatched++; $display("FAIL par_lsr_latency: got %0d want 2", lat); end
        for (int md = 0; md < 4; md++) begin
            run_op(1'b1, 32'hA5A51234, 5'd0, md[1:0], r, c, z, lat);
            compared++;
            if (r !== 32'hA5A51234 || c !== 1'b0 || z !== 1'b0 || lat != 2) begin
                mismatched++;
                $display("FAIL par_n0_mode%0d: got %h c=%b z=%b lat=%0d want a5a51234 c=0 z=0 lat=2", md, r, c, z, lat);
            end
        end
        run_op(1'b1, 32'h00000001, 5'd31, 2'b11, r, c, z, lat);
        compared++; if (r !== 32'h00000002 || c !== 1'b0) begin mismatched++; $display("FAIL par_ror31: got %h c=%b want 00000002 c=0", r, c); end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr_lsr();
        test_ror_lsl_carry();
        test_backpressure();
        test_reset_mid_shift();
        test_parallel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
